ex_muldiv: RTL and testbench

EX_MULDIV -- requirements
Module: ex_muldiv

---
 rtl/ex_muldiv.sv | 122 ++++++++++++
 tb/tb_ex_muldiv.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
// RV32M execute-stage multiply/divide unit: single-cycle 33x33 multiply,
// 32-cycle restoring divide, divide special cases resolved without iterating.
//
// state | meaning
// IDLE  | waiting for an M-extension instruction in EX
// MUL   | product formed from latched operands, result registered
// DIV   | one quotient bit per cycle on operand magnitudes
// DONE  | md_result valid, instruction advances out of EX
module ex_muldiv (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [6:0]  EX_op,
  input  logic [2:0]  EX_funct3,
  input  logic [6:0]  EX_funct7,
  input  logic [31:0] EX_rs1_data,
  input  logic [31:0] EX_rs2_data,
  output logic        md_stall,
  output logic        md_valid,
  output logic [31:0] md_result
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t      state, state_nxt;
  logic        req, div_signed, div_zero, div_ovf, special;
  logic [31:0] a_mag, b_mag;
  logic [31:0] op_a, op_b, rem;
  logic [1:0]  f3;
  logic        mul_sa, mul_sb, neg_q, neg_r;
  logic [5:0]  cnt;

  logic signed [32:0] mul_a, mul_b;
  logic signed [63:0] prod;
  logic [32:0] rem_sh, diff;
  logic [31:0] rem_nxt, quo_nxt;

  assign req        = (EX_op == 7'b0110011) && (EX_funct7 == 7'b0000001) && !flush;
  assign div_signed = !EX_funct3[0];
  assign div_zero   = (EX_rs2_data == 32'h0);
  assign div_ovf    = div_signed && (EX_rs1_data == 32'h80000000) && (EX_rs2_data == 32'hFFFFFFFF);
  assign special    = EX_funct3[2] && (div_zero || div_ovf);
  assign a_mag      = (div_signed && EX_rs1_data[31]) ? -EX_rs1_data : EX_rs1_data;
  assign b_mag      = (div_signed && EX_rs2_data[31]) ? -EX_rs2_data : EX_rs2_data;

  assign mul_a = {mul_sa & op_a[31], op_a};
  assign mul_b = {mul_sb & op_b[31], op_b};
  assign prod  = 64'(mul_a) * 64'(mul_b);

  // op_a doubles as the dividend/quotient shift register during DIV
  assign rem_sh  = {rem, op_a[31]};
  assign diff    = rem_sh - {1'b0, op_b};
  assign rem_nxt = diff[32] ? rem_sh[31:0] : diff[31:0];
  assign quo_nxt = {op_a[30:0], !diff[32]};

  always_comb begin
    state_nxt = state;
    md_stall  = 1'b0;
    case (state)
      IDLE: if (req) state_nxt = !EX_funct3[2] ? MUL : (special ? DONE : DIV);
      MUL:  state_nxt = DONE;
      DIV:  if (cnt == 6'd1) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
    if (!rst && !flush)
      md_stall = (req && state != DONE) || state == MUL || state == DIV;
  end

  assign md_valid = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 6'd0;
      op_a      <= 32'h0;
      op_b      <= 32'h0;
      rem       <= 32'h0;
      f3        <= 2'b00;
      mul_sa    <= 1'b0;
      mul_sb    <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      md_result <= 32'h0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (req) begin
          f3  <= EX_funct3[1:0];
          rem <= 32'h0;
          cnt <= 6'd32;
          if (!EX_funct3[2]) begin
            op_a   <= EX_rs1_data;
            op_b   <= EX_rs2_data;
            mul_sa <= (EX_funct3[1:0] != 2'b11);
            mul_sb <= !EX_funct3[1];
          end else begin
            op_a  <= a_mag;
            op_b  <= b_mag;
            neg_q <= div_signed && (EX_rs1_data[31] ^ EX_rs2_data[31]);
            neg_r <= div_signed && EX_rs1_data[31];
            if (special)
              md_result <= div_zero ? (EX_funct3[1] ? EX_rs1_data : 32'hFFFFFFFF)
                                    : (EX_funct3[1] ? 32'h0 : 32'h80000000);
          end
        end
        MUL: if (!flush) md_result <= (f3 == 2'b00) ? prod[31:0] : prod[63:32];
        DIV: if (!flush) begin
          op_a <= quo_nxt;
          rem  <= rem_nxt;
          cnt  <= cnt - 6'd1;
          if (cnt == 6'd1)
            md_result <= f3[1] ? (neg_r ? -rem_nxt : rem_nxt)
                               : (neg_q ? -quo_nxt : quo_nxt);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed scenarios plus random ops
// compared against an arithmetic reference model.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic [6:0]  EX_op, EX_funct7;
  logic [2:0]  EX_funct3;
  logic [31:0] EX_rs1_data, EX_rs2_data;
  logic        md_stall, md_valid;
  logic [31:0] md_result;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] last_res = 32'h0;

  ex_muldiv dut (
    .clk(clk), .rst(rst), .flush(flush),
    .EX_op(EX_op), .EX_funct3(EX_funct3), .EX_funct7(EX_funct7),
    .EX_rs1_data(EX_rs1_data), .EX_rs2_data(EX_rs2_data),
    .md_stall(md_stall), .md_valid(md_valid), .md_result(md_result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, ub, p;
    longint unsigned up;
    int              ia, ib, q;
    logic [31:0]     r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'h0, b});
    ia = $signed(a);
    ib = $signed(b);
    r  = 32'h0;
    case (f3)
      3'd0: begin p = sa * sb; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin up = {32'h0, a} * {32'h0, b}; r = up[63:32]; end
      3'd4: if (b == 0) r = 32'hFFFFFFFF;
            else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h80000000;
            else begin q = ia / ib; r = q; end
      3'd5: r = (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: if (b == 0) r = a;
            else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h0;
            else begin q = ia % ib; r = q; end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (!f3[2]) return 2;
    if (b == 0) return 1;
    if (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
    return 33;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    EX_op       = 7'b0110011;
    EX_funct7   = 7'b0000001;
    EX_funct3   = f3;
    EX_rs1_data = a;
    EX_rs2_data = b;
  endtask

  task automatic clr();
    EX_op     = 7'h0;
    EX_funct7 = 7'h0;
  endtask

  // Starts on a cycle boundary, ends at the negedge of the cycle after DONE.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int          cyc, stalls, lat;
    bit          got;
    logic [31:0] exp;
    exp = model(f3, a, b);
    lat = latency(f3, a, b);
    @(posedge clk); #1;
    set_m(f3, a, b);
    cyc = 0; stalls = 0; got = 0;
    while (!got && cyc < 60) begin
      @(negedge clk);
      if (md_valid) got = 1;
      else begin
        if (md_stall) stalls++;
        @(posedge clk); #1;
        cyc++;
      end
    end
    chk({tag, "_valid"}, 32'(got), 32'd1);
    chk({tag, "_lat"}, cyc, lat);
    chk({tag, "_stalls"}, stalls, lat);
    chk({tag, "_stall_done"}, 32'(md_stall), 32'd0);
    chk({tag, "_result"}, md_result, exp);
    @(posedge clk); #1;
    clr();
    last_res = exp;
    @(negedge clk);
    chk({tag, "_valid_after"}, 32'(md_valid), 32'd0);
    chk({tag, "_hold"}, md_result, last_res);
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a, b;
    rst = 1'b1; flush = 1'b0;
    EX_funct3 = 3'd0; EX_rs1_data = 32'h0; EX_rs2_data = 32'h0;
    clr();
    #12;
    set_m(3'd0, 32'd1, 32'd2);
    #1;
    chk("rst_stall", 32'(md_stall), 32'd0);
    chk("rst_valid", 32'(md_valid), 32'd0);
    chk("rst_result", md_result, 32'h0);
    clr();
    @(posedge clk); #1;
    rst = 1'b0;

    run_op("mul_dir", 3'd0, 32'd7, 32'hFFFFFFFD);
    chk("mul_dir_const", md_result, 32'hFFFFFFEB);
    run_op("mulh_dir", 3'd1, 32'h80000000, 32'h80000000);
    chk("mulh_dir_const", md_result, 32'h40000000);
    run_op("mulhu_dir", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_op("div_dir", 3'd4, 32'hFFFFFFF9, 32'd2);
    chk("div_dir_const", md_result, 32'hFFFFFFFD);
    run_op("rem_dir", 3'd6, 32'hFFFFFFF9, 32'd2);
    run_op("divu_zero", 3'd5, 32'd5, 32'd0);
    run_op("div_ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF);
    run_op("rem_ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF);
    run_op("mulhsu_dir", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);

    // non-M R-type instruction
    @(posedge clk); #1;
    EX_op = 7'b0110011; EX_funct7 = 7'h0; EX_funct3 = 3'd4;
    @(negedge clk);
    chk("nonm_stall", 32'(md_stall), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("nonm_stall2", 32'(md_stall), 32'd0);
    chk("nonm_valid", 32'(md_valid), 32'd0);
    clr();

    // flush during a divide
    @(posedge clk); #1;
    set_m(3'd5, 32'd1000, 32'd3);
    repeat (10) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(negedge clk);
    chk("flush_stall", 32'(md_stall), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    clr();
    @(negedge clk);
    chk("flush_valid", 32'(md_valid), 32'd0);
    chk("flush_idle_stall", 32'(md_stall), 32'd0);
    chk("flush_hold", md_result, last_res);
    run_op("mul_after_flush", 3'd0, 32'd3, 32'd4);
    chk("mul_after_flush_const", md_result, 32'd12);

    // flush coinciding with a new request
    @(posedge clk); #1;
    set_m(3'd0, 32'd5, 32'd6);
    flush = 1'b1;
    @(negedge clk);
    chk("flushreq_stall", 32'(md_stall), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    clr();
    @(negedge clk);
    chk("flushreq_stall_next", 32'(md_stall), 32'd0);
    chk("flushreq_valid_next", 32'(md_valid), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("flushreq_valid_late", 32'(md_valid), 32'd0);

    // reset mid-divide
    @(posedge clk); #1;
    set_m(3'd4, 32'hFFFFFF9C, 32'd7);
    repeat (20) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    chk("midrst_stall", 32'(md_stall), 32'd0);
    chk("midrst_valid", 32'(md_valid), 32'd0);
    chk("midrst_result", md_result, 32'h0);
    last_res = 32'h0;
    @(posedge clk); #1;
    rst = 1'b0;
    clr();
    run_op("divu_100_7", 3'd5, 32'd100, 32'd7);
    chk("divu_100_7_const", md_result, 32'd14);
    run_op("remu_100_7", 3'd7, 32'd100, 32'd7);
    chk("remu_100_7_const", md_result, 32'd2);

    for (int i = 0; i < 30; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: b = -32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      run_op("rand", f3, a, b);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
